// File: rtl/pll_lock_reset_seq.sv
// PLL lock qualifier: synchronizes rPLL lock, debounces it, retries on timeout and sequences the system reset.
// Optional retry limit with a terminal FAIL state is enabled by defining PLLSEQ_RETRY_LIMIT_EN.
module pll_lock_reset_seq #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned CNT_W              = 20,
    parameter int unsigned MAX_RETRIES        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic       failed
);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || MAX_RETRIES < 1) begin : g_chk_min
        $error("PLL_RST_CYCLES, LOCK_TIMEOUT and MAX_RETRIES must be at least 1");
    end
    if (((PLL_RST_CYCLES - 1) >> CNT_W) != 0 || ((LOCK_TIMEOUT - 1) >> CNT_W) != 0 ||
        (LOCK_STABLE_CYCLES >> CNT_W) != 0) begin : g_chk_cnt
        $error("CNT_W too narrow for the configured cycle counts");
    end

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES);

`ifdef PLLSEQ_RETRY_LIMIT_EN
    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
`else
    typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         retry_d, loss_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               lock_s;
    logic               pll_reset_d, run_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_cnt;
        loss_d  = loss_cnt;
        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // Entry edge already counts as the first stable sample.
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_cnt != 8'hFF) begin
                        retry_d = retry_cnt + 8'd1;
                    end
`ifdef PLLSEQ_RETRY_LIMIT_EN
                    if (retry_cnt == 8'(MAX_RETRIES - 1)) begin
                        state_d = FAIL;
                    end else begin
                        state_d = PLL_RST;
                    end
`else
                    state_d = PLL_RST;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    if (loss_cnt != 8'hFF) begin
                        loss_d = loss_cnt + 8'd1;
                    end
                end
            end
`ifdef PLLSEQ_RETRY_LIMIT_EN
            FAIL: begin
                state_d = FAIL;
            end
`endif
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the transition.
    always_comb begin
        pll_reset_d = (state_d == PLL_RST);
        run_d       = (state_d == RUN);
`ifdef PLLSEQ_RETRY_LIMIT_EN
        if (state_d == FAIL) begin
            pll_reset_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_cnt <= retry_d;
            loss_cnt  <= loss_d;
            pll_reset <= pll_reset_d;
            sys_rst_n <= run_d;
            ready     <= run_d;
        end
    end

`ifdef PLLSEQ_RETRY_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            failed <= 1'b0;
        end else begin
            failed <= (state_d == FAIL);
        end
    end
`else
    assign failed = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Randomized self-checking bench for pll_lock_reset_seq against a phase/dwell-time reference model.
// Define PLLSEQ_RETRY_LIMIT_EN for both bench and RTL to exercise the retry-limit build.
module tb_pll_lock_reset_seq;
    localparam int SS  = 2;
    localparam int PRC = 4;
    localparam int LT  = 32;
    localparam int LSC = 8;
    localparam int MR  = 2;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic       failed;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_reset_seq #(
        .SYNC_STAGES(SS),
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT(LT),
        .LOCK_STABLE_CYCLES(LSC),
        .CNT_W(16),
        .MAX_RETRIES(MR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pll_lock(pll_lock),
        .pll_reset(pll_reset),
        .sys_rst_n(sys_rst_n),
        .ready(ready),
        .retry_cnt(retry_cnt),
        .loss_cnt(loss_cnt),
        .failed(failed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which phase we are in and how long we have dwelt there.
    typedef enum int {PH_RST, PH_WAIT, PH_STAB, PH_RUN, PH_FAIL} ph_t;
    ph_t ph;
    int  dwell, hi_run, m_retry, m_loss;
    bit  lq[$];

    function automatic void mreset();
        ph = PH_RST; dwell = 0; hi_run = 0; m_retry = 0; m_loss = 0;
        lq.delete();
        for (int i = 0; i < SS; i++) lq.push_back(1'b0);
    endfunction

    function automatic void enter(input ph_t p);
        ph = p; dwell = 0;
    endfunction

    function automatic void mstep(input bit lock_in);
        bit ls;
        ls = lq.pop_front();
        lq.push_back(lock_in);
        dwell++;
        case (ph)
            PH_RST: if (dwell == PRC) enter(PH_WAIT);
            PH_WAIT: begin
                if (ls) begin
                    enter(PH_STAB); hi_run = 1;
                end else if (dwell == LT) begin
`ifdef PLLSEQ_RETRY_LIMIT_EN
                    enter(m_retry == MR - 1 ? PH_FAIL : PH_RST);
`else
                    enter(PH_RST);
`endif
                    m_retry = (m_retry >= 255) ? 255 : m_retry + 1;
                end
            end
            PH_STAB: begin
                if (!ls) enter(PH_WAIT);
                else begin
                    hi_run++;
                    if (hi_run == LSC + 1) enter(PH_RUN);
                end
            end
            PH_RUN: begin
                if (!ls) begin
                    enter(PH_RST);
                    m_loss = (m_loss >= 255) ? 255 : m_loss + 1;
                end
            end
            default: ;
        endcase
    endfunction

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) mreset();
            else mstep(pll_lock);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("pll_reset", pll_reset, (ph == PH_RST || ph == PH_FAIL));
            chk("sys_rst_n", sys_rst_n, (ph == PH_RUN));
            chk("ready", ready, (ph == PH_RUN));
            chk("retry_cnt", retry_cnt, m_retry);
            chk("loss_cnt", loss_cnt, m_loss);
            chk("failed", failed, (ph == PH_FAIL));
        end
    end

    task automatic edges_until(input logic want, output int n, output bit saw_pr);
        n = 0; saw_pr = 1'b0;
        forever begin
            @(posedge clk); n++;
            @(negedge clk);
            saw_pr |= pll_reset;
            if (sys_rst_n === want) break;
            if (n >= 600) begin n = -1; break; end
        end
    endtask

    task automatic count_pll_reset(input int start, output int c);
        c = start;
        forever begin
            @(negedge clk);
            if (!pll_reset || c >= 100) break;
            c++;
        end
    endtask

    task automatic pulse_reset(input string tag, input int off);
        @(posedge clk);
        #(off) rst_n = 1'b0;
        #1;
        chk({tag, "_pll_reset"}, pll_reset, 1);
        chk({tag, "_sys_rst_n"}, sys_rst_n, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_retry"}, retry_cnt, 0);
        chk({tag, "_loss"}, loss_cnt, 0);
        chk({tag, "_failed"}, failed, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, c;
        bit saw, saw2;
        rst_n = 1'b0;
        pll_lock = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("por_pll_reset", pll_reset, 1);
        chk("por_sys_rst_n", sys_rst_n, 0);
        chk("por_retry", retry_cnt, 0);

        // Plain acquisition with late lock.
        @(posedge clk); #2 rst_n = 1'b1;
        count_pll_reset(0, c);
        chk("s1_pll_reset_len", c, PRC);
        repeat (6) @(posedge clk);
        #2 pll_lock = 1'b1;
        edges_until(1'b1, n, saw);
        chk("s1_release_latency", n - 1, 10);
        chk("s1_ready", ready, 1);
        chk("s1_retry", retry_cnt, 0);

        // Lock loss in RUN for 5 cycles.
        @(posedge clk); #2 pll_lock = 1'b0;
        fork
            begin repeat (5) @(posedge clk); #2 pll_lock = 1'b1; end
        join_none
        edges_until(1'b0, n, saw);
        chk("s4_loss_latency", n - 1, 2);
        chk("s4_ready_low", ready, 0);
        count_pll_reset(pll_reset ? 1 : 0, c);
        chk("s4_pll_reset_len", c, PRC);
        chk("s4_loss_cnt", loss_cnt, 1);
        edges_until(1'b1, n, saw);
        chk("s4_rerelease", sys_rst_n, 1);

        // Reset in RUN, lock already high at release.
        pulse_reset("s5_run", 3);
        count_pll_reset(0, c);
        chk("s5_lock_high_pll_reset_len", c, PRC);
        edges_until(1'b1, n, saw);
        chk("s5_release", sys_rst_n, 1);

        // One-cycle lock drop, then reset while debouncing.
        @(posedge clk); #2 pll_lock = 1'b0;
        @(posedge clk); #2 pll_lock = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("s5_stable_loss", loss_cnt, 1);
        chk("s5_stable_sys_rst_n", sys_rst_n, 0);
        pll_lock = 1'b0;
        pulse_reset("s5_stable", 3);

        // Lock drop during STABLE.
        repeat (6) @(posedge clk);
        #2 pll_lock = 1'b1;
        repeat (5) @(posedge clk);
        #2 pll_lock = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk); saw |= pll_reset;
            @(posedge clk);
        end
        #2 pll_lock = 1'b1;
        edges_until(1'b1, n, saw2);
        chk("s3_release_latency", n - 1, 10);
        chk("s3_no_pll_reset", saw | saw2, 0);
        chk("s3_retry", retry_cnt, 0);

        // Lock never arrives.
        pll_lock = 1'b0;
        pulse_reset("s2", 2);
        repeat (120) @(posedge clk);
        @(negedge clk);
`ifdef PLLSEQ_RETRY_LIMIT_EN
        chk("s6_retry", retry_cnt, 2);
        chk("s6_failed", failed, 1);
        chk("s6_pll_reset", pll_reset, 1);
        @(posedge clk); #2 pll_lock = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("s6_fail_sticky", failed, 1);
        chk("s6_fail_sys_rst_n", sys_rst_n, 0);
        chk("s6_fail_retry", retry_cnt, 2);
        pll_lock = 1'b0;
`else
        chk("s2_retry", retry_cnt, 3);
        chk("s2_sys_rst_n", sys_rst_n, 0);
        repeat (9200) @(posedge clk);
        @(negedge clk);
        chk("s2_retry_saturate", retry_cnt, 255);
`endif

        // Repeated lock losses until loss_cnt saturates.
        pll_lock = 1'b1;
        pulse_reset("sat", 1);
        for (int i = 0; i < 260; i++) begin
            edges_until(1'b1, n, saw);
            if (n < 0) begin
                chk("sat_reacquire", n, 0);
                break;
            end
            @(posedge clk); #2 pll_lock = 1'b0;
            repeat (2) @(posedge clk);
            #2 pll_lock = 1'b1;
        end
        edges_until(1'b1, n, saw);
        chk("loss_saturate", loss_cnt, 255);

        // Random lock activity with occasional asynchronous resets.
        pulse_reset("rnd0", 2);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                pulse_reset("rnd", int'($urandom_range(1, 3)));
            end else begin
                @(posedge clk);
                #($urandom_range(1, 4)) pll_lock = 1'($urandom_range(0, 1));
                repeat ($urandom_range(0, 60)) @(posedge clk);
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
